// File: rtl/heart_pkg.sv
// Shared encodings for the LED heart sequencer.
//   mode_e  : pattern selection as seen on the mode input
//   state_e : sequencer FSM state encoding
//   N_LED_DEF / CNT_W_DEF / REPS_W : default sizes
package heart_pkg;

   localparam int unsigned N_LED_DEF = 12;
   localparam int unsigned CNT_W_DEF = 8;
   localparam int unsigned REPS_W    = 4;

   typedef enum logic [1:0] {
      MODE_FILL  = 2'd0,
      MODE_CHASE = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_SOLID = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FINISH = 2'd2
   } state_e;

endpackage

// File: rtl/heart_frame_timer.sv
// Frame-period counter. Counts 0..P-1 (P = max(period,1)) while en is high
// and pulses tick on the last cycle of each frame.
//   clk, reset (sync, active-low), en (advance), clr (restart at 0),
//   period (cycles per frame), tick (last cycle of frame, gated by en)
module heart_frame_timer #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  logic [CNT_W-1:0] period,
   output logic             tick
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] last_c;

   // period 0 behaves like period 1, so the last count is 0 in both cases
   assign last_c = (period == '0) ? '0 : period - CNT_W'(1);
   assign tick   = en && (count_q == last_c);

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (en) begin
         count_q <= tick ? '0 : count_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/heart_seq_ctrl.sv
// LED heart sequencer: plays FILL / CHASE / BLINK / SOLID patterns on led,
// one step per frame, for reps loops (0 = until stop).
//   clk, reset (sync, active-low)
//   start / stop : single-cycle requests; pause : level, freezes frame timing
//   mode, period, reps : configuration latched on an accepted start
//   led : registered pattern drive; busy : in RUN
//   frame_tick : last cycle of each frame; done : one-cycle completion pulse
module heart_seq_ctrl
   import heart_pkg::*;
#(
   parameter int unsigned N_LED = N_LED_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic              pause,
   input  logic [1:0]        mode,
   input  logic [CNT_W-1:0]  period,
   input  logic [REPS_W-1:0] reps,
   output logic [N_LED-1:0]  led,
   output logic              busy,
   output logic              frame_tick,
   output logic              done
);

   localparam int unsigned STEP_W = (N_LED > 2) ? $clog2(N_LED) : 1;
   localparam logic [REPS_W-1:0] LOOP_MAX = '1;

   state_e              state_q, state_n;
   mode_e               mode_q, mode_n;
   logic [CNT_W-1:0]    period_q, period_n;
   logic [REPS_W-1:0]   reps_q, reps_n;
   logic [STEP_W-1:0]   step_q, step_n;
   logic [REPS_W-1:0]   loop_q, loop_n;
   logic [N_LED-1:0]    led_n;
   logic                busy_n, done_n;
   logic                timer_en_c, timer_clr_c, tick_c;
   logic [REPS_W-1:0]   loop_inc_c;

   // LED image for step k of pattern m
   function automatic logic [N_LED-1:0] pattern(mode_e m, logic [STEP_W-1:0] k);
      logic [N_LED-1:0] p;
      p = '0;
      case (m)
         MODE_FILL:  for (int i = 0; i < int'(N_LED); i++) p[i] = (i <= int'(k));
         MODE_CHASE: for (int i = 0; i < int'(N_LED); i++) p[i] = (i == int'(k));
         MODE_BLINK: p = (k == '0) ? '1 : '0;
         default:    p = '1;
      endcase
      return p;
   endfunction

   // index of the final step of one loop for pattern m
   function automatic logic [STEP_W-1:0] last_step(mode_e m);
      case (m)
         MODE_FILL, MODE_CHASE: return STEP_W'(N_LED - 1);
         MODE_BLINK:            return STEP_W'(1);
         default:               return '0;
      endcase
   endfunction

   assign timer_en_c = (state_q == ST_RUN) && !pause;
   assign loop_inc_c = (loop_q == LOOP_MAX) ? LOOP_MAX : loop_q + REPS_W'(1);
   assign frame_tick = tick_c;

   heart_frame_timer #(.CNT_W(CNT_W)) u_timer (
      .clk    (clk),
      .reset  (reset),
      .en     (timer_en_c),
      .clr    (timer_clr_c),
      .period (period_q),
      .tick   (tick_c)
   );

   // Next-state and next-output logic
   always_comb begin
      state_n     = state_q;
      mode_n      = mode_q;
      period_n    = period_q;
      reps_n      = reps_q;
      step_n      = step_q;
      loop_n      = loop_q;
      led_n       = led;
      timer_clr_c = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start && !stop) begin
               state_n     = ST_RUN;
               mode_n      = mode_e'(mode);
               period_n    = period;
               reps_n      = reps;
               step_n      = '0;
               loop_n      = '0;
               led_n       = pattern(mode_e'(mode), '0);
               timer_clr_c = 1'b1;
            end
         end
         ST_RUN: begin
            // stop takes priority over any frame boundary in the same cycle
            if (stop) begin
               state_n     = ST_IDLE;
               led_n       = '0;
               timer_clr_c = 1'b1;
            end else if (tick_c) begin
               if (step_q == last_step(mode_q)) begin
                  step_n = '0;
                  loop_n = loop_inc_c;
                  if (reps_q != '0 && loop_inc_c == reps_q) begin
                     state_n = ST_FINISH;
                     led_n   = '0;
                  end else begin
                     led_n = pattern(mode_q, '0);
                  end
               end else begin
                  step_n = step_q + STEP_W'(1);
                  led_n  = pattern(mode_q, step_q + STEP_W'(1));
               end
            end
         end
         ST_FINISH: begin
            state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
            led_n   = '0;
         end
      endcase

      busy_n = (state_n == ST_RUN);
      done_n = (state_n == ST_FINISH);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         mode_q   <= MODE_FILL;
         period_q <= '0;
         reps_q   <= '0;
         step_q   <= '0;
         loop_q   <= '0;
         led      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state_q  <= state_n;
         mode_q   <= mode_n;
         period_q <= period_n;
         reps_q   <= reps_n;
         step_q   <= step_n;
         loop_q   <= loop_n;
         led      <= led_n;
         busy     <= busy_n;
         done     <= done_n;
      end
   end

endmodule

// File: tb/tb_heart_seq_ctrl.sv
// Self-checking bench for heart_seq_ctrl: directed scenarios with literal
// checks, plus a cycle-by-cycle comparison against a behavioural model.
module tb_heart_seq_ctrl;

   logic        clk = 1'b0;
   logic        reset, start, stop, pause;
   logic [1:0]  mode;
   logic [7:0]  period;
   logic [3:0]  reps;
   logic [11:0] led;
   logic        busy, frame_tick, done;

   int total = 0;
   int bad   = 0;
   int done_seen = 0;

   always #5 clk = ~clk;

   heart_seq_ctrl #(.N_LED(12), .CNT_W(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .stop       (stop),
      .pause      (pause),
      .mode       (mode),
      .period     (period),
      .reps       (reps),
      .led        (led),
      .busy       (busy),
      .frame_tick (frame_tick),
      .done       (done)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural reference ----------------
   int m_state = 0;   // 0 idle, 1 run, 2 finish
   int m_cnt = 0, m_step = 0, m_loop = 0;
   int m_mode = 0, m_per = 0, m_reps = 0;
   int m_led = 0;

   function automatic int pat(input int m, input int k);
      case (m)
         0:       return (1 << (k + 1)) - 1;
         1:       return 1 << k;
         2:       return (k == 0) ? 32'hFFF : 0;
         default: return 32'hFFF;
      endcase
   endfunction

   function automatic int seq_len(input int m);
      return (m < 2) ? 12 : ((m == 2) ? 2 : 1);
   endfunction

   function automatic int frame_len();
      return (m_per == 0) ? 1 : m_per;
   endfunction

   always @(posedge clk) begin
      bit t;
      t = (m_state == 1) && !pause && (m_cnt == frame_len() - 1);
      if (!reset) begin
         m_state = 0; m_cnt = 0; m_step = 0; m_loop = 0;
         m_mode = 0; m_per = 0; m_reps = 0; m_led = 0;
      end else begin
         case (m_state)
            0: if (start && !stop) begin
                  m_mode = int'(mode); m_per = int'(period); m_reps = int'(reps);
                  m_cnt = 0; m_step = 0; m_loop = 0; m_state = 1;
                  m_led = pat(m_mode, 0);
               end
            1: if (stop) begin
                  m_state = 0; m_led = 0;
               end else if (!pause) begin
                  if (t) begin
                     m_cnt = 0;
                     m_step++;
                     if (m_step == seq_len(m_mode)) begin
                        m_step = 0;
                        if (m_loop < 15) m_loop++;
                        if (m_reps != 0 && m_loop == m_reps) begin
                           m_state = 2; m_led = 0;
                        end else begin
                           m_led = pat(m_mode, 0);
                        end
                     end else begin
                        m_led = pat(m_mode, m_step);
                     end
                  end else begin
                     m_cnt++;
                  end
               end
            default: m_state = 0;
         endcase
      end
      #2;
      chk("model_led",  32'(led),        32'(m_led));
      chk("model_busy", 32'(busy),       32'(m_state == 1));
      chk("model_done", 32'(done),       32'(m_state == 2));
      chk("model_tick", 32'(frame_tick),
          32'((m_state == 1) && !pause && (m_cnt == frame_len() - 1)));
      if (done === 1'b1) done_seen++;
   end

   // ---------------- directed scenarios ----------------
   initial begin
      reset = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
      mode = 2'd0; period = 8'd0; reps = 4'd0;
      repeat (3) @(negedge clk);
      chk("rst_led",  32'(led), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_tick", 32'(frame_tick), 32'h0);
      reset = 1'b1;
      @(negedge clk);

      // start and stop together in IDLE are ignored
      start = 1'b1; stop = 1'b1;
      @(negedge clk);
      chk("startstop_busy", 32'(busy), 32'h0);
      start = 1'b0; stop = 1'b0;
      @(negedge clk);

      // FILL, period 2, reps 1; config churn and a start pulse while running
      mode = 2'd0; period = 8'd2; reps = 4'd1; start = 1'b1;
      done_seen = 0;
      for (int c = 1; c <= 27; c++) begin
         @(negedge clk);
         if (c == 1)  chk("fill_c1_led",  32'(led), 32'h001);
         if (c == 2)  chk("fill_c2_tick", 32'(frame_tick), 32'h1);
         if (c == 3)  chk("fill_c3_led",  32'(led), 32'h003);
         if (c == 24) chk("fill_c24_led", 32'(led), 32'hFFF);
         if (c == 25) begin
            chk("fill_c25_done", 32'(done), 32'h1);
            chk("fill_c25_led",  32'(led),  32'h0);
            chk("fill_c25_busy", 32'(busy), 32'h0);
         end
         if (c == 26) chk("fill_c26_done", 32'(done), 32'h0);
         if (c == 1)  start = 1'b0;
         if (c == 3)  begin mode = 2'd1; period = 8'd5; reps = 4'd0; end
         if (c == 10) start = 1'b1;
         if (c == 11) start = 1'b0;
      end
      chk("fill_done_count", 32'(done_seen), 32'd1);

      // CHASE, period 0, reps 2
      mode = 2'd1; period = 8'd0; reps = 4'd2; start = 1'b1;
      done_seen = 0;
      for (int c = 1; c <= 27; c++) begin
         @(negedge clk);
         if (c == 1)  chk("chase_c1_led",  32'(led), 32'h001);
         if (c == 12) chk("chase_c12_led", 32'(led), 32'h800);
         if (c == 13) chk("chase_c13_led", 32'(led), 32'h001);
         if (c == 24) chk("chase_c24_led", 32'(led), 32'h800);
         if (c == 25) chk("chase_c25_done", 32'(done), 32'h1);
         if (c == 1)  start = 1'b0;
      end
      chk("chase_done_count", 32'(done_seen), 32'd1);

      // BLINK, period 3, endless, stopped after 20 cycles
      mode = 2'd2; period = 8'd3; reps = 4'd0; start = 1'b1;
      done_seen = 0;
      for (int c = 1; c <= 26; c++) begin
         @(negedge clk);
         if (c == 1)  chk("blink_c1_led", 32'(led), 32'hFFF);
         if (c == 3)  chk("blink_c3_tick", 32'(frame_tick), 32'h1);
         if (c == 4)  chk("blink_c4_led", 32'(led), 32'h000);
         if (c == 7)  chk("blink_c7_led", 32'(led), 32'hFFF);
         if (c == 20) chk("blink_c20_led", 32'(led), 32'hFFF);
         if (c == 21) begin
            chk("blink_stop_led",  32'(led),  32'h0);
            chk("blink_stop_busy", 32'(busy), 32'h0);
         end
         if (c == 1)  start = 1'b0;
         if (c == 20) stop = 1'b1;
         if (c == 21) stop = 1'b0;
      end
      chk("blink_done_count", 32'(done_seen), 32'd0);

      // SOLID, period 4, pause held for 10 edges mid-frame
      mode = 2'd3; period = 8'd4; reps = 4'd0; start = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if (c == 4)  chk("solid_c4_tick",  32'(frame_tick), 32'h0);
         if (c == 8)  chk("solid_c8_led",   32'(led), 32'hFFF);
         if (c == 12) chk("solid_c12_tick", 32'(frame_tick), 32'h0);
         if (c == 13) chk("solid_c13_tick", 32'(frame_tick), 32'h0);
         if (c == 14) begin
            chk("solid_c14_tick", 32'(frame_tick), 32'h1);
            chk("solid_c14_led",  32'(led), 32'hFFF);
         end
         if (c == 1)  start = 1'b0;
         if (c == 2)  pause = 1'b1;
         if (c == 12) pause = 1'b0;
         if (c == 16) stop = 1'b1;
      end
      @(negedge clk);
      stop = 1'b0;
      @(negedge clk);

      // reset during RUN at step 5, then a fresh start with a new mode
      mode = 2'd0; period = 8'd1; reps = 4'd0; start = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 6) chk("rst5_led_before", 32'(led), 32'h03F);
         if (c == 7) begin
            chk("rst5_led",  32'(led),  32'h0);
            chk("rst5_busy", 32'(busy), 32'h0);
            chk("rst5_done", 32'(done), 32'h0);
            chk("rst5_tick", 32'(frame_tick), 32'h0);
         end
         if (c == 1) start = 1'b0;
         if (c == 6) reset = 1'b0;
         if (c == 7) reset = 1'b1;
      end
      mode = 2'd1; period = 8'd1; reps = 4'd1; start = 1'b1;
      done_seen = 0;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         if (c == 1)  chk("after_rst_led", 32'(led), 32'h001);
         if (c == 13) chk("after_rst_done", 32'(done), 32'h1);
         if (c == 1)  start = 1'b0;
      end
      chk("after_rst_done_count", 32'(done_seen), 32'd1);

      // stop coincident with the final frame_tick
      mode = 2'd1; period = 8'd1; reps = 4'd1; start = 1'b1;
      done_seen = 0;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         if (c == 12) begin
            chk("stopfin_tick", 32'(frame_tick), 32'h1);
            chk("stopfin_led",  32'(led), 32'h800);
         end
         if (c == 13) begin
            chk("stopfin_led0", 32'(led),  32'h0);
            chk("stopfin_busy", 32'(busy), 32'h0);
            chk("stopfin_done", 32'(done), 32'h0);
         end
         if (c == 1)  start = 1'b0;
         if (c == 12) stop = 1'b1;
         if (c == 13) stop = 1'b0;
      end
      chk("stopfin_done_count", 32'(done_seen), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
